// File: rtl/geofence_sqrt_sched.sv
// geofence_sqrt_sched
// Shared square-root scheduler: a round-robin arbiter picks one of NREQ requesters and
// feeds its radicand to a single iterative digit-by-digit (two bits per cycle) root engine.
// The result is broadcast with the owning requester's index.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester radicand valid
//   req_data   radicands, requester i at [i*DW +: DW]
//   req_ready  one-hot accept strobe (IDLE only)
//   res_valid  one-cycle result strobe
//   res_id     requester index owning the result (held until next result)
//   res_root   root, OW+1 bits (held until next result)
//   busy       high while a root is being computed or presented
//
// Build option: define GEOFENCE_SQRT_ROUND_EN for round-to-nearest results; otherwise the
// result is the floor square root.

module geofence_sqrt_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [DW/2:0]           res_root,
    output logic                    busy
);

    localparam int unsigned OW = DW / 2;
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(OW + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [DW-1:0]   rad_q, rad_d;
    logic [OW+1:0]   rem_q, rem_d;
    logic [OW-1:0]   root_q, root_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   res_id_q, res_id_d;
    logic [OW:0]     res_root_q, res_root_d;

    logic [IW-1:0]   sel, cand;
    logic            found;

    logic [OW+3:0]   rem_sh;
    logic [OW+1:0]   sub, trial, rem_nx;
    logic [OW-1:0]   root_nx;
    logic            take;

    // Round-robin pick: first valid requester at or above ptr, wrapping.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = IW'((int'(ptr_q) + i) % int'(NREQ));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // One root digit: compare the shifted remainder against 4*root+1.
    always_comb begin
        rem_sh  = {rem_q, rad_q[DW-1:DW-2]};
        sub     = {root_q, 2'b01};
        take    = rem_sh >= {2'b00, sub};
        // When taken the true difference is at most 2*root, so OW+2 bits hold it exactly.
        trial   = rem_sh[OW+1:0] - sub;
        rem_nx  = take ? trial : rem_sh[OW+1:0];
        root_nx = {root_q[OW-2:0], take};
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        cnt_d      = cnt_q;
        res_id_d   = res_id_q;
        res_root_d = res_root_q;
        req_ready  = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    // Keep the strobe low while reset holds the engine.
                    req_ready[sel] = ~reset;
                    rad_d          = req_data[sel*DW +: DW];
                    id_d           = sel;
                    rem_d          = '0;
                    root_d         = '0;
                    cnt_d          = '0;
                    ptr_d          = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
                    state_d        = StCalc;
                end
            end
            StCalc: begin
                rem_d  = rem_nx;
                root_d = root_nx;
                rad_d  = {rad_q[DW-3:0], 2'b00};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(OW - 1)) begin
                    state_d  = StDone;
                    res_id_d = id_q;
`ifdef GEOFENCE_SQRT_ROUND_EN
                    // rem > root means rad >= root^2+root+1, so sqrt exceeds root+0.5.
                    if (rem_nx > {2'b00, root_nx}) begin
                        res_root_d = {1'b0, root_nx} + {{OW{1'b0}}, 1'b1};
                    end else begin
                        res_root_d = {1'b0, root_nx};
                    end
`else
                    res_root_d = {1'b0, root_nx};
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            id_q       <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            res_id_q   <= '0;
            res_root_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
            res_id_q   <= res_id_d;
            res_root_q <= res_root_d;
        end
    end

    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign res_id    = res_id_q;
    assign res_root  = res_root_q;

endmodule

// File: tb/tb_geofence_sqrt_sched.sv
// Testbench for geofence_sqrt_sched: directed scenarios plus randomized traffic, with a
// cycle-level reference model (arithmetic square root + round-robin grant rule) checked
// against every DUT output on each falling clock edge.
module tb_geofence_sqrt_sched;

    localparam int NREQ = 4;
    localparam int DW   = 40;
    localparam int OW   = DW / 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic [1:0]          res_id;
    logic [OW:0]         res_root;
    logic                busy;

    geofence_sqrt_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_root  (res_root),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference square root by binary search, then optional rounding.
    function automatic longint unsigned m_sqrt(input longint unsigned v);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << (OW + 1);
        longint unsigned mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
`ifdef GEOFENCE_SQRT_ROUND_EN
        if (v - lo * lo > lo) lo = lo + 1;
`endif
        return lo;
    endfunction

    // ---------------- reference model + compare process ----------------
    bit              m_has = 0;
    int              m_t = 0, m_done = 0, m_ptr = 0, m_pid = 0, m_res_id = 0;
    longint unsigned m_proot = 0, m_res_root = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              exp_busy, exp_rv;
        int              sel;
        exp_ready = '0;
        if (reset) begin
            m_has = 0; m_ptr = 0; m_res_id = 0; m_res_root = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_root", res_root, 0);
        end else begin
            exp_busy = m_has && cyc > m_t && cyc <= m_done;
            exp_rv   = m_has && cyc == m_done;
            if (exp_rv) begin
                m_res_id   = m_pid;
                m_res_root = m_proot;
            end
            if (!(m_has && cyc <= m_done) && (|req_valid)) begin
                sel = -1;
                for (int k = 0; k < NREQ; k++)
                    if (sel < 0 && req_valid[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
                exp_ready[sel] = 1'b1;
                m_has   = 1;
                m_t     = cyc;
                m_done  = cyc + OW + 1;
                m_pid   = sel;
                m_proot = m_sqrt(64'(req_data[sel*DW +: DW]));
                m_ptr   = (sel + 1) % NREQ;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("res_valid", res_valid, exp_rv);
            chk("res_id", res_id, m_res_id);
            chk("res_root", res_root, m_res_root);
        end
    end

    // ---------------- helpers (called at posedge+1) ----------------
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready(input int id, output int t);
        bit ok = 0;
        t = -1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1; t = cyc; end
        end
        if (!ok) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_any(output int t, output int gid);
        bit ok = 0;
        t = -1; gid = -1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin ok = 1; t = cyc; gid = i; end
        end
        if (!ok) chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic wait_res(output int t, output int rid, output logic [63:0] root);
        bit ok = 0;
        t = -1; rid = -1; root = '1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; t = cyc; rid = res_id; root = 64'(res_root); end
        end
        if (!ok) chk("wait_res_timeout", 0, 1);
    endtask

    task automatic run_one(input int id, input logic [DW-1:0] rad, output int acc_lat,
                           output int lat, output int rid, output logic [63:0] root);
        int t0, tg, tr;
        t0 = cyc;
        req_data[id*DW +: DW] = rad;
        req_valid[id] = 1'b1;
        wait_ready(id, tg);
        acc_lat = tg - t0;
        @(posedge clk); #1 req_valid[id] = 1'b0;
        wait_res(tr, rid, root);
        lat = tr - tg;
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rnd_rad();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return DW'($urandom_range(0, 300));
            default: return r[DW-1:0];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [DW-1:0]   rads [5];
        longint unsigned exps [5];
        logic [63:0]     root;
        logic [NREQ-1:0] acc;
        int              acc_lat, lat, rid, tg, tg2, tr, trel, t, gid;
        int              gids [5];
        int              gts [5];

        rads[0] = DW'(1000000); rads[1] = DW'(12); rads[2] = DW'(13);
        rads[3] = '0;           rads[4] = '1;
`ifdef GEOFENCE_SQRT_ROUND_EN
        exps = '{1000, 3, 4, 0, 1048576};
`else
        exps = '{1000, 3, 3, 0, 1048575};
`endif
        // Pin the reference model itself.
        for (int k = 0; k < 5; k++) chk("model_pin", m_sqrt(64'(rads[k])), exps[k]);

        do_reset(3);

        // Single requester directed roots.
        for (int k = 0; k < 5; k++) begin
            run_one(k % NREQ, rads[k], acc_lat, lat, rid, root);
            chk("dir_accept_lat", acc_lat, 0);
            chk("dir_res_lat", lat, OW + 1);
            chk("dir_res_id", rid, k % NREQ);
            chk("dir_root", root, exps[k]);
        end

        // All four valid out of reset: grants 0,1,2,3,0 spaced OW+2 apart.
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(1000 + i * 777777);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        trel = cyc;
        for (int g = 0; g < 5; g++) begin
            wait_any(t, gid);
            gids[g] = gid; gts[g] = t;
        end
        chk("rr_first_grant", gts[0] - trel, 0);
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant_id", gids[g], g % NREQ);
            if (g > 0) chk("rr_spacing", gts[g] - gts[g-1], OW + 2);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (25) @(posedge clk);
        #1;

        // Requester 2 granted, then 1 (and optionally 3) raise valid mid-CALC.
        for (int k = 0; k < 2; k++) begin
            do_reset(2);
            req_data[2*DW +: DW] = rnd_rad();
            req_valid = 4'b0100;
            wait_ready(2, tg);
            @(posedge clk); #1 req_valid[2] = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            req_data[1*DW +: DW] = rnd_rad();
            req_data[3*DW +: DW] = rnd_rad();
            req_valid[1] = 1'b1;
            if (k == 1) req_valid[3] = 1'b1;
            wait_any(t, gid);
            chk("ptr_wrap_grant", gid, (k == 1) ? 3 : 1);
            chk("ptr_wrap_time", t - tg, OW + 2);
            @(posedge clk); #1 req_valid = '0;
            repeat (25) @(posedge clk);
            #1;
        end

        // Reset pulsed in CALC cycle 5 aborts; held request re-granted on release.
        do_reset(2);
        req_data[0 +: DW] = rnd_rad();
        req_valid = 4'b0001;
        wait_ready(0, tg);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        trel = cyc;
        wait_ready(0, tg2);
        chk("abort_regrant", tg2 - trel, 0);
        @(posedge clk); #1 req_valid = '0;
        wait_res(tr, rid, root);
        chk("abort_res_lat", tr - tg2, OW + 1);
        @(posedge clk); #1;

        // Randomized traffic with occasional reset pulses.
        do_reset(2);
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else req_data[i*DW +: DW] = rnd_rad();
                end else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
                    req_data[i*DW +: DW] = rnd_rad();
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid = '0;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/geofence_sqrt_sched.md
# geofence_sqrt_sched

Shared square-root scheduler for the geofence datapath. Up to NREQ requesters (Heron-formula and edge-length stages) present radicands. A round-robin arbiter grants one at a time to a single iterative digit-by-digit square-root engine. The result returns on a broadcast bus tagged with the requester index. This replaces per-term combinational root units with one sequential engine at the cost of latency.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 40, radicand width; must be even; root width OW = DW/2 (derived localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester radicand valid
- req_data  in  NREQ*DW  radicands, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept strobe
- res_valid  out  1  result strobe, one cycle
- res_id  out  clog2(NREQ)  index of requester owning result
- res_root  out  OW+1  root; MSB only nonzero with rounding enabled
- busy  out  1  high in CALC and DONE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready[sel] = 1 combinationally in IDLE only; all other req_ready bits are 0.
  - On handshake: latch req_data[sel] into rad, latch sel into id, clear rem/root, cnt=0, ptr <= (sel+1) mod NREQ, go to CALC.
  - If no req_valid is set, stay in IDLE.
- CALC, one digit per cycle, OW cycles:
  - trial = {rem, rad[DW-1:DW-2]} − {root, 2'b01}, rem width OW+2.
  - If trial ≥ 0: rem <= trial, root <= {root,1}. Else: rem <= {rem, rad top 2 bits}, root <= {root,0}.
  - rad <= rad << 2; cnt++. When cnt == OW−1, go to DONE.
- DONE:
  - res_valid=1, res_id=id, res_root=final root (rounded per Configuration).
  - Next state is IDLE unconditionally.
- Requester protocol: hold req_valid and req_data stable until req_ready. Changes to req_valid in CALC/DONE are ignored.
- A requester still valid after its result competes normally. Round-robin guarantees every other valid requester is served before it is granted again.
- Arithmetic is unsigned. Floor result satisfies root² ≤ rad < (root+1)².

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, res_valid=0, res_id=0, res_root=0, busy=0.
- Handshake in cycle t gives res_valid in cycle t+OW+1 (DW=40: t+21).
- A new grant is possible in cycle t+OW+2. Peak throughput is one root per OW+2 cycles.
- res_id and res_root are held stable after res_valid drops, until the next DONE.
- Reset asserted mid-CALC or in DONE aborts the operation with no res_valid; the aborted requester is not retained and must still be holding req_valid to be served after reset.
- Simultaneous requests are resolved in the same IDLE cycle; exactly one req_ready bit is high.

## Configuration
- GEOFENCE_SQRT_ROUND_EN defined:
  - In DONE, if final rem > root, res_root = root+1; otherwise res_root = root. This is round-to-nearest, since rad ≥ root²+root+1 implies sqrt > root+0.5.
  - res_root[OW] may be 1, e.g. for an all-ones radicand.
- Not defined: res_root = {1'b0, root}, a floor result.

## Test plan
- Single requester 0, rad=1_000_000: req_ready[0] in the accept cycle; res_valid 21 cycles later with res_id=0, res_root=1000; busy high throughout.
- rad=12 and rad=13: floor build gives 3 and 3; GEOFENCE_SQRT_ROUND_EN build gives 3 and 4. rad=0 gives 0 in both builds.
- rad=2^40−1: floor 1048575; rounded 1048576 with res_root[20]=1.
- All four requesters valid from reset with distinct radicands: grants 0,1,2,3, then 0 again if still valid. res_id sequence matches; each grant is spaced 22 cycles apart.
- Requester 2 granted, then requester 1 raises valid mid-CALC: next grant goes to 3 if valid, else 1 (ptr=3 wraps); requester 2's result is unaffected.
- Reset pulsed in CALC cycle 5: no res_valid; all outputs return to reset values; ptr=0; a held request is re-granted in the first cycle after reset releases.
